// File: rtl/exec_fwd_reg_pkg.sv
// Shared types for the execute-to-forwarding pipeline register: FU ids,
// per-slot destination tags, the FU result bundle and the register's state.
package exec_fwd_reg_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   typedef enum logic [2:0] {
      FU_NONE = 3'd0,
      FU_ALU1 = 3'd1,
      FU_ALU2 = 3'd2,
      FU_BRU  = 3'd3,
      FU_MMU  = 3'd4,
      FU_HILO = 3'd5
   } fu_t;

   typedef struct packed {
      logic [REG_W-1:0] target_reg;
      fu_t              fu;
      logic             we;
   } exec_reg_t;

   typedef struct packed {
      logic [DATA_W-1:0] alu1_result;
      logic [DATA_W-1:0] alu2_result;
      logic [DATA_W-1:0] bru_link_pc;
      logic [DATA_W-1:0] mmu_result;
      logic [DATA_W-1:0] hilo_result;
   } exec_result_t;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      WAIT_MMU = 2'd1,
      HOLD     = 2'd2,
      DISCARD  = 2'd3
   } exec_fwd_state_t;

   localparam exec_reg_t EXEC_REG_RESET = '{target_reg: '0, fu: FU_NONE, we: 1'b0};

   // A slot only waits on the MMU when it will actually write a register.
   function automatic logic needs_mmu(exec_reg_t r);
      return (r.fu == FU_MMU) && r.we;
   endfunction

endpackage

// File: rtl/exec_fwd_reg_if.sv
// Execute-bundle input, MMU load-data return and forwarding output of the
// exec_fwd_reg pipeline register, bundled as one interface.
interface exec_fwd_reg_if;
   import exec_fwd_reg_pkg::*;

   // Handshakes are strict valid/ready: a transfer happens on a rising clk edge
   // where valid and ready are both high; the producer keeps valid and its
   // payload stable until then, and ready may depend combinationally on the
   // consumer's ready. mmu_data_valid is a one-cycle strobe with no ready.
   logic              in_valid;
   logic              in_ready;
   exec_reg_t         in_reg1;
   exec_reg_t         in_reg2;
   logic [DATA_W-1:0] in_alu1_result;
   logic [DATA_W-1:0] in_alu2_result;
   logic [DATA_W-1:0] in_bru_link_pc;
   logic [DATA_W-1:0] in_hilo_result;
   logic              mmu_data_valid;
   logic [DATA_W-1:0] mmu_data;
   logic              out_valid;
   logic              out_ready;
   exec_result_t      exec_result;
   exec_reg_t         exec_reg1;
   exec_reg_t         exec_reg2;

   modport master (
      output in_valid, in_reg1, in_reg2, in_alu1_result, in_alu2_result,
             in_bru_link_pc, in_hilo_result, mmu_data_valid, mmu_data, out_ready,
      input  in_ready, out_valid, exec_result, exec_reg1, exec_reg2
   );

   modport slave (
      input  in_valid, in_reg1, in_reg2, in_alu1_result, in_alu2_result,
             in_bru_link_pc, in_hilo_result, mmu_data_valid, mmu_data, out_ready,
      output in_ready, out_valid, exec_result, exec_reg1, exec_reg2
   );

endinterface

// File: rtl/exec_fwd_reg.sv
// Pipeline register between the execute FUs and the delayed-exec ALU stage:
// holds one bundle of tags and FU results, waiting out variable MMU latency.
module exec_fwd_reg
   import exec_fwd_reg_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush,
   exec_fwd_reg_if.slave   bus,
   output exec_fwd_state_t dbg_state
);

   exec_fwd_state_t state;
   logic            out_valid;
   exec_result_t    result;
   exec_reg_t       reg1;
   exec_reg_t       reg2;
   logic            ready;
   logic            accept;
   logic            needs;

   always_comb begin
      ready = 1'b0;
      case (state)
         EMPTY:   ready = 1'b1;
         HOLD:    ready = bus.out_ready;
         default: ready = 1'b0;
      endcase
   end

   assign accept = bus.in_valid && ready && !flush;
   assign needs  = needs_mmu(bus.in_reg1) || needs_mmu(bus.in_reg2);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         result    <= '0;
         reg1      <= EXEC_REG_RESET;
         reg2      <= EXEC_REG_RESET;
      end else begin
         case (state)
            EMPTY, HOLD: begin
               if (flush) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
                  reg1.we   <= 1'b0;
                  reg2.we   <= 1'b0;
               end else if (accept) begin
                  reg1               <= bus.in_reg1;
                  reg2               <= bus.in_reg2;
                  result.alu1_result <= bus.in_alu1_result;
                  result.alu2_result <= bus.in_alu2_result;
                  result.bru_link_pc <= bus.in_bru_link_pc;
                  result.hilo_result <= bus.in_hilo_result;
                  // Non-MMU bundles leave the last MMU value in place.
                  if (!needs) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                  end else if (bus.mmu_data_valid) begin
                     result.mmu_result <= bus.mmu_data;
                     state             <= HOLD;
                     out_valid         <= 1'b1;
                  end else begin
                     state     <= WAIT_MMU;
                     out_valid <= 1'b0;
                  end
               end else if ((state == HOLD) && bus.out_ready) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
                  reg1.we   <= 1'b0;
                  reg2.we   <= 1'b0;
               end
            end
            WAIT_MMU: begin
               if (flush) begin
                  // Data still in flight for the dead bundle must be swallowed.
                  state   <= bus.mmu_data_valid ? EMPTY : DISCARD;
                  reg1.we <= 1'b0;
                  reg2.we <= 1'b0;
               end else if (bus.mmu_data_valid) begin
                  result.mmu_result <= bus.mmu_data;
                  state             <= HOLD;
                  out_valid         <= 1'b1;
               end
            end
            DISCARD: begin
               if (!flush && bus.mmu_data_valid) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign bus.in_ready    = ready;
   assign bus.out_valid   = out_valid;
   assign bus.exec_result = result;
   assign bus.exec_reg1   = reg1;
   assign bus.exec_reg2   = reg2;
   assign dbg_state       = state;

   a_single_mmu_slot: assert property (@(posedge clk) disable iff (!resetn)
      accept |-> !(needs_mmu(bus.in_reg1) && needs_mmu(bus.in_reg2)));

endmodule
